// File: rtl/i2c_slave.sv
// I2C target that emulates a small byte-addressed register file.
// SCL/SDA are oversampled by clk; all bus decisions are taken on
// synchronized edge events, and SDA is only changed on SCL falling events.
module i2c_slave #(
  parameter logic [6:0] SLAVE_ADDRESS = 7'h76,
  parameter int         ADDR_WIDTH    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  scl,
  input  logic                  sda_in,
  output logic                  sda_out,
  input  logic                  ext_load_en,
  input  logic [ADDR_WIDTH-1:0] ext_load_addr,
  input  logic [7:0]            ext_load_data,
  output logic [7:0]            ext_data_out,
  output logic                  ext_wr_strobe,
  output logic [ADDR_WIDTH-1:0] ext_wr_addr,
  output logic                  busy
);

  localparam int                    DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [3:0]            LAST_BIT  = 4'd7;
  localparam logic [3:0]            BYTE_DONE = 4'd8;

  typedef enum logic [2:0] {
    IDLE,      // ignore the bus until a START
    ADDR,      // shift in 7-bit address + R/W
    ADDR_ACK,  // drive address ACK for one SCL period
    REG,       // shift in register pointer byte
    WDATA,     // shift in write data byte
    WACK,      // drive ACK after pointer or data byte
    RDATA,     // shift out read data byte
    RACK       // sample the master's ACK/NACK
  } state_t;

  logic scl_s1, scl_s2, scl_d;
  logic sda_s1, sda_s2, sda_d;
  logic scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] rx_byte;

  state_t                state, state_n;
  logic [3:0]            bit_cnt, bit_cnt_n;
  logic [7:0]            rx_sr, rx_sr_n;
  logic [7:0]            tx_sr, tx_sr_n;
  logic                  sda_q, sda_q_n;
  logic                  rw, rw_n;
  logic                  mack, mack_n;
  logic                  busy_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n;
  logic                  wr_en;
  logic [7:0]            regs [DEPTH];

  // Two-flop synchronizers plus a history flop for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {scl_s1, scl_s2, scl_d} <= 3'b111;
      {sda_s1, sda_s2, sda_d} <= 3'b111;
    end else begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge
      // value, so the chain really is three stages deep.
      scl_s1 <= scl;
      scl_s2 <= scl_s1;
      scl_d  <= scl_s2;
      sda_s1 <= sda_in;
      sda_s2 <= sda_s1;
      sda_d  <= sda_s2;
    end
  end

  assign scl_rise = scl_s2 & ~scl_d;
  assign scl_fall = ~scl_s2 & scl_d;
  assign start_ev = scl_s2 & scl_d & sda_d & ~sda_s2;
  assign stop_ev  = scl_s2 & scl_d & ~sda_d & sda_s2;
  assign rx_byte  = {rx_sr[6:0], sda_s2};

  // Next-state logic: START/STOP override everything, else per-state bit handling.
  always_comb begin
    // NOTE: every variable gets its hold value first so no path infers a latch.
    state_n   = state;
    bit_cnt_n = bit_cnt;
    rx_sr_n   = rx_sr;
    tx_sr_n   = tx_sr;
    sda_q_n   = sda_q;
    rw_n      = rw;
    mack_n    = mack;
    busy_n    = busy;
    ptr_n     = ptr;
    wr_en     = 1'b0;

    if (start_ev) begin
      state_n   = ADDR;
      bit_cnt_n = '0;
      sda_q_n   = 1'b1;
      busy_n    = 1'b1;
    end else if (stop_ev) begin
      state_n = IDLE;
      sda_q_n = 1'b1;
      busy_n  = 1'b0;
    end else begin
      unique case (state)
        IDLE: ;
        ADDR, REG, WDATA: begin
          if (scl_rise && bit_cnt < BYTE_DONE) begin
            rx_sr_n   = rx_byte;
            bit_cnt_n = bit_cnt + 4'd1;
            if (bit_cnt == LAST_BIT && state == REG) begin
              ptr_n = rx_byte[ADDR_WIDTH-1:0];
            end
            if (bit_cnt == LAST_BIT && state == WDATA) begin
              wr_en = 1'b1;
              ptr_n = ptr + PTR_ONE;
            end
          end else if (scl_fall && bit_cnt == BYTE_DONE) begin
            if (state != ADDR) begin
              sda_q_n = 1'b0;
              state_n = WACK;
            end else if (rx_sr[7:1] == SLAVE_ADDRESS) begin
              sda_q_n = 1'b0;
              rw_n    = rx_sr[0];
              state_n = ADDR_ACK;
            end else begin
              sda_q_n = 1'b1;
              state_n = IDLE;
            end
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (!rw) begin
              sda_q_n   = 1'b1;
              bit_cnt_n = '0;
              state_n   = REG;
            end else begin
              sda_q_n   = regs[ptr][7];
              tx_sr_n   = {regs[ptr][6:0], 1'b0};
              bit_cnt_n = 4'd1;
              state_n   = RDATA;
            end
          end
        end
        WACK: begin
          if (scl_fall) begin
            sda_q_n   = 1'b1;
            bit_cnt_n = '0;
            state_n   = WDATA;
          end
        end
        RDATA: begin
          if (scl_fall) begin
            if (bit_cnt == BYTE_DONE) begin
              sda_q_n = 1'b1;
              ptr_n   = ptr + PTR_ONE;
              state_n = RACK;
            end else begin
              sda_q_n   = tx_sr[7];
              tx_sr_n   = {tx_sr[6:0], 1'b0};
              bit_cnt_n = bit_cnt + 4'd1;
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            mack_n = sda_s2;
          end else if (scl_fall) begin
            if (!mack) begin
              sda_q_n   = regs[ptr][7];
              tx_sr_n   = {regs[ptr][6:0], 1'b0};
              bit_cnt_n = 4'd1;
              state_n   = RDATA;
            end else begin
              sda_q_n = 1'b1;
              state_n = IDLE;
            end
          end
        end
      endcase
    end
  end

  // FSM state, shifters, pointer and host-side write report.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      bit_cnt       <= '0;
      rx_sr         <= '0;
      tx_sr         <= '0;
      sda_q         <= 1'b1;
      rw            <= 1'b0;
      mack          <= 1'b1;
      busy          <= 1'b0;
      ptr           <= '0;
      ext_wr_strobe <= 1'b0;
      ext_data_out  <= '0;
      ext_wr_addr   <= '0;
    end else begin
      state         <= state_n;
      bit_cnt       <= bit_cnt_n;
      rx_sr         <= rx_sr_n;
      tx_sr         <= tx_sr_n;
      sda_q         <= sda_q_n;
      rw            <= rw_n;
      mack          <= mack_n;
      busy          <= busy_n;
      ptr           <= ptr_n;
      ext_wr_strobe <= wr_en;
      if (wr_en) begin
        ext_data_out <= rx_byte;
        ext_wr_addr  <= ptr;
      end
    end
  end

  // Register file: host preload first, bus write last so the bus wins a collision.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the file is small and must read back as zero after reset, so it
      // is built from resettable flops rather than a RAM macro.
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
    end else begin
      if (ext_load_en) regs[ext_load_addr] <= ext_load_data;
      if (wr_en)       regs[ptr]           <= rx_byte;
    end
  end

  assign sda_out = sda_q;

endmodule

// File: tb/tb_i2c_slave.sv
// Bench for i2c_slave: a bit-banged bus master, a transaction-level register
// model, and scoreboard monitors for write strobes and returned read bytes.
module tb_i2c_slave;

  localparam int         AW    = 4;
  localparam int         DEPTH = 16;
  localparam int         Q     = 8;        // clk cycles per quarter SCL period
  localparam logic [6:0] SADDR = 7'h76;

  logic          clk = 1'b0;
  logic          rst;
  logic          scl, sda_in, sda_out;
  logic          ext_load_en;
  logic [AW-1:0] ext_load_addr;
  logic [7:0]    ext_load_data;
  logic [7:0]    ext_data_out;
  logic          ext_wr_strobe;
  logic [AW-1:0] ext_wr_addr;
  logic          busy;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t           exp_wr [$];
  logic [7:0]    exp_rd [$];
  logic [7:0]    got_rd [$];
  logic [7:0]    model_mem [DEPTH];
  logic [AW-1:0] model_ptr;

  i2c_slave #(.SLAVE_ADDRESS(SADDR), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .scl(scl), .sda_in(sda_in), .sda_out(sda_out),
    .ext_load_en(ext_load_en), .ext_load_addr(ext_load_addr),
    .ext_load_data(ext_load_data), .ext_data_out(ext_data_out),
    .ext_wr_strobe(ext_wr_strobe), .ext_wr_addr(ext_wr_addr), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, run did not complete");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: pops expectations whenever the DUT reports a write or a byte is read.
  always @(negedge clk) begin : scoreboard
    wr_t        e;
    logic [7:0] g, x;
    if (rst && ext_wr_strobe) begin
      if (exp_wr.size() == 0) begin
        errors++; checks++;
        $display("FAIL wr_unexpected: strobe addr=%0d data=0x%0h with none expected", ext_wr_addr, ext_data_out);
      end else begin
        e = exp_wr.pop_front();
        check("wr_addr", ext_wr_addr, e.addr);
        check("wr_data", ext_data_out, e.data);
      end
    end
    while (got_rd.size() > 0) begin
      g = got_rd.pop_front();
      if (exp_rd.size() == 0) begin
        errors++; checks++;
        $display("FAIL rd_unexpected: got 0x%0h with none expected", g);
      end else begin
        x = exp_rd.pop_front();
        check("rd_data", g, x);
      end
    end
  end

  // SDA from the target must not move while SCL is held high.
  logic scl_prev = 1'b1, sda_prev = 1'b1;
  always @(negedge clk) begin
    if (rst && scl && scl_prev && sda_out !== sda_prev) begin
      errors++; checks++;
      $display("FAIL sda_stable: sda_out changed to %0b while scl high", sda_out);
    end
    scl_prev <= scl;
    sda_prev <= sda_out;
  end

  task automatic wait_q();
    repeat (Q) @(negedge clk);
  endtask

  task automatic i2c_start();
    sda_in = 1'b1; wait_q(); scl = 1'b1; wait_q(); sda_in = 1'b0; wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic i2c_stop();
    sda_in = 1'b0; wait_q(); scl = 1'b1; wait_q(); sda_in = 1'b1; wait_q();
  endtask

  task automatic write_bit(input logic b);
    sda_in = b; wait_q(); scl = 1'b1; wait_q(); wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic read_bit(output logic b);
    sda_in = 1'b1; wait_q(); scl = 1'b1; wait_q(); b = sda_out; wait_q(); scl = 1'b0; wait_q();
  endtask

  task automatic write_byte(input logic [7:0] d, input logic exp_ack, input string name);
    logic a;
    for (int i = 7; i >= 0; i--) write_bit(d[i]);
    read_bit(a);
    check(name, a, exp_ack);
  endtask

  task automatic read_byte(input logic nack);
    logic [7:0] d;
    logic       b;
    for (int i = 7; i >= 0; i--) begin
      read_bit(b);
      d[i] = b;
    end
    write_bit(nack);
    got_rd.push_back(d);
  endtask

  // Last data bit is raised while a preload is held until the bus commit is seen.
  task automatic write_byte_load(input logic [7:0] d, input logic [AW-1:0] la, input logic [7:0] ld);
    logic a;
    bit   seen;
    for (int i = 7; i >= 1; i--) write_bit(d[i]);
    sda_in = d[0]; wait_q(); scl = 1'b1;
    ext_load_addr = la; ext_load_data = ld; ext_load_en = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 * Q && !seen; k++) begin
      @(negedge clk);
      if (ext_wr_strobe) seen = 1'b1;
    end
    ext_load_en = 1'b0;
    check("collision_commit_seen", {31'd0, seen}, 1);
    wait_q(); wait_q(); scl = 1'b0; wait_q();
    read_bit(a);
    check("ack_data_collide", a, 0);
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [7:0] d);
    @(negedge clk);
    ext_load_addr = a; ext_load_data = d; ext_load_en = 1'b1;
    @(negedge clk);
    ext_load_en = 1'b0;
    model_mem[a] = d;
  endtask

  task automatic bus_write(input logic [6:0] a7, input logic [7:0] rg, input int n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
    logic [7:0] d [3];
    logic       hit;
    d[0] = d0; d[1] = d1; d[2] = d2;
    hit = (a7 == SADDR);
    i2c_start();
    check("busy_after_start", busy, 1);
    write_byte({a7, 1'b0}, !hit, "ack_addr_w");
    if (hit) model_ptr = rg[AW-1:0];
    write_byte(rg, !hit, "ack_reg");
    for (int i = 0; i < n; i++) begin
      if (hit) begin
        exp_wr.push_back('{addr: model_ptr, data: d[i]});
        model_mem[model_ptr] = d[i];
        model_ptr++;
      end
      write_byte(d[i], !hit, "ack_data");
    end
    i2c_stop();
    check("busy_after_stop", busy, 0);
  endtask

  task automatic bus_read(input logic set_ptr, input logic [7:0] rg, input int n);
    i2c_start();
    check("busy_after_start", busy, 1);
    if (set_ptr) begin
      write_byte({SADDR, 1'b0}, 1'b0, "ack_addr_w");
      model_ptr = rg[AW-1:0];
      write_byte(rg, 1'b0, "ack_reg");
      i2c_start();
    end
    write_byte({SADDR, 1'b1}, 1'b0, "ack_addr_r");
    for (int i = 0; i < n; i++) begin
      exp_rd.push_back(model_mem[model_ptr]);
      model_ptr++;
      read_byte(i == n - 1);
    end
    i2c_stop();
    check("busy_after_stop", busy, 0);
  endtask

  initial begin
    logic       b;
    logic [7:0] r;
    int         op, n;

    rst = 1'b0; scl = 1'b1; sda_in = 1'b1;
    ext_load_en = 1'b0; ext_load_addr = '0; ext_load_data = '0;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    model_ptr = '0;
    repeat (4) @(negedge clk);
    check("rst_sda_out", sda_out, 1);
    check("rst_busy", busy, 0);
    check("rst_wr_strobe", ext_wr_strobe, 0);
    check("rst_data_out", ext_data_out, 0);
    check("rst_wr_addr", ext_wr_addr, 0);
    rst = 1'b1;
    repeat (4) @(negedge clk);

    // Single write, then an address mismatch, then read both back.
    bus_write(SADDR, 8'h04, 1, 8'h27, 8'h00, 8'h00);
    bus_write(7'h77, 8'h01, 1, 8'h55, 8'h00, 8'h00);
    bus_read(1'b1, 8'h01, 1);
    bus_read(1'b1, 8'h04, 1);

    // Burst read across the top of the file.
    preload(4'd14, 8'hA5);
    preload(4'd15, 8'h3C);
    bus_read(1'b1, 8'h0E, 3);

    // Burst write wrapping 15 -> 0.
    bus_write(SADDR, 8'h0F, 2, 8'h11, 8'h22, 8'h00);
    bus_read(1'b1, 8'h0F, 2);

    // Preload colliding with a bus commit (same index), then a different index.
    i2c_start();
    write_byte({SADDR, 1'b0}, 1'b0, "ack_addr_w");
    model_ptr = 4'd4;
    write_byte(8'h04, 1'b0, "ack_reg");
    model_mem[4] = 8'h99;
    exp_wr.push_back('{addr: 4'd4, data: 8'h5A});
    model_mem[4] = 8'h5A;
    model_ptr++;
    write_byte_load(8'h5A, 4'd4, 8'h99);
    model_mem[9] = 8'h77;
    exp_wr.push_back('{addr: 4'd5, data: 8'h6B});
    model_mem[5] = 8'h6B;
    model_ptr++;
    write_byte_load(8'h6B, 4'd9, 8'h77);
    i2c_stop();
    bus_read(1'b1, 8'h04, 6);

    // STOP in the middle of a data byte discards it.
    preload(4'd7, 8'hC3);
    i2c_start();
    write_byte({SADDR, 1'b0}, 1'b0, "ack_addr_w");
    model_ptr = 4'd7;
    write_byte(8'h07, 1'b0, "ack_reg");
    for (int i = 0; i < 4; i++) write_bit(1'b0);
    i2c_stop();
    check("busy_after_mid_stop", busy, 0);
    bus_read(1'b1, 8'h07, 1);

    // Repeated START in the middle of a data byte aborts it; the next write lands.
    i2c_start();
    write_byte({SADDR, 1'b0}, 1'b0, "ack_addr_w");
    model_ptr = 4'd2;
    write_byte(8'h02, 1'b0, "ack_reg");
    for (int i = 0; i < 5; i++) write_bit(1'b0);
    bus_write(SADDR, 8'h02, 1, 8'hE1, 8'h00, 8'h00);
    bus_read(1'b1, 8'h02, 1);

    // Randomized mix of preloads, writes (some to a foreign address) and reads.
    for (int t = 0; t < 10; t++) begin
      op = $urandom_range(0, 2);
      n  = $urandom_range(1, 3);
      if (op == 0) begin
        preload(AW'($urandom), 8'($urandom));
      end else if (op == 1) begin
        bus_write(($urandom_range(0, 3) == 0) ? 7'($urandom) : SADDR, 8'($urandom), n,
                  8'($urandom), 8'($urandom), 8'($urandom));
      end else begin
        bus_read(1'($urandom), 8'($urandom), n + 1);
      end
    end

    // Reset during the 5th bit of a read byte while the target drives SDA low.
    preload(4'd3, 8'h00);
    preload(4'd9, 8'hFF);
    i2c_start();
    write_byte({SADDR, 1'b0}, 1'b0, "ack_addr_w");
    write_byte(8'h03, 1'b0, "ack_reg");
    i2c_start();
    write_byte({SADDR, 1'b1}, 1'b0, "ack_addr_r");
    for (int i = 0; i < 4; i++) read_bit(b);
    sda_in = 1'b1; wait_q(); scl = 1'b1; wait_q();
    check("sda_driven_before_rst", sda_out, 0);
    check("busy_before_rst", busy, 1);
    #2;
    rst = 1'b0;
    #1;
    check("rst_abort_sda_out", sda_out, 1);
    check("rst_abort_busy", busy, 0);
    wait_q();
    rst = 1'b1;
    for (int i = 0; i < DEPTH; i++) model_mem[i] = 8'h00;
    model_ptr = '0;
    wait_q();
    check("rst_abort_data_out", ext_data_out, 0);
    check("rst_abort_wr_addr", ext_wr_addr, 0);
    bus_read(1'b0, 8'h00, DEPTH);

    repeat (4) @(negedge clk);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    r = 8'h00;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
